mem_stage: RTL and testbench

Load/store stage of the mriscv pipeline, placed directly after `execute`. It is the consumer of execute's `result`/`dest_o` and owns the `is_load`/`is_store` path: it turns the effective address and store operand into a handshaked data-memory transaction, aligns and extends load data, and presents a single write-back beat to the register file. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mriscv_pkg.sv | 20 ++
 rtl/mem_align.sv | 110 +++++++++++
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mriscv_pkg.sv
// Shared definitions for the mriscv pipeline.
// Contents: the data/address width, the load/store func3 encodings,
// and the mem_stage FSM state encoding.
package mriscv_pkg;

    localparam int XLEN = 32;

    // func3 encodings for loads and stores (B/H/W signed or store, BU/HU unsigned loads)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational data alignment for the load/store stage.
// Store side : is_load, is_store, func3, addr_lo, store_data -> wdata, wstrb, access_ok
//              (access_ok = func3 legal for the class and address aligned to the size;
//               an instruction flagged both load and store is treated as a load)
// Load side  : ld_func3, ld_off, rdata -> ld_data (byte/half extraction, sign/zero extend)
module mem_align
    import mriscv_pkg::*;
(
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      func3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb,
    output logic            access_ok,
    input  logic [2:0]      ld_func3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic       store_sel_s;
    logic [7:0] ld_byte_s;
    logic [15:0] ld_half_s;

    assign store_sel_s = is_store & ~is_load;

    // Store lane replication and byte strobes; loads drive no strobes
    always_comb begin
        wdata = {XLEN{1'b0}};
        wstrb = 4'b0000;
        if (store_sel_s) begin
            case (func3)
                F3_B: begin
                    wdata = {4{store_data[7:0]}};
                    wstrb = 4'b0001 << addr_lo;
                end
                F3_H: begin
                    wdata = {2{store_data[15:0]}};
                    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                F3_W: begin
                    wdata = store_data;
                    wstrb = 4'b1111;
                end
                default: begin
                    wdata = {XLEN{1'b0}};
                    wstrb = 4'b0000;
                end
            endcase
        end else begin
            wdata = {XLEN{1'b0}};
            wstrb = 4'b0000;
        end
    end

    // Legality of func3 for the access class plus natural alignment
    always_comb begin
        access_ok = 1'b0;
        if (is_load) begin
            case (func3)
                F3_B, F3_BU: access_ok = 1'b1;
                F3_H, F3_HU: access_ok = ~addr_lo[0];
                F3_W:        access_ok = (addr_lo == 2'b00);
                default:     access_ok = 1'b0;
            endcase
        end else if (is_store) begin
            case (func3)
                F3_B:    access_ok = 1'b1;
                F3_H:    access_ok = ~addr_lo[0];
                F3_W:    access_ok = (addr_lo == 2'b00);
                default: access_ok = 1'b0;
            endcase
        end else begin
            access_ok = 1'b1;
        end
    end

    // Byte and halfword lane selection from the returned word
    always_comb begin
        ld_byte_s = 8'h00;
        case (ld_off)
            2'b00:   ld_byte_s = rdata[7:0];
            2'b01:   ld_byte_s = rdata[15:8];
            2'b10:   ld_byte_s = rdata[23:16];
            2'b11:   ld_byte_s = rdata[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        if (ld_off[1]) begin
            ld_half_s = rdata[31:16];
        end else begin
            ld_half_s = rdata[15:0];
        end
    end

    // Sign or zero extension according to the registered load func3
    always_comb begin
        ld_data = rdata;
        case (ld_func3)
            F3_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_BU:   ld_data = {24'h000000, ld_byte_s};
            F3_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_HU:   ld_data = {16'h0000, ld_half_s};
            F3_W:    ld_data = rdata;
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage of the mriscv pipeline.
// Upstream  : in_valid/in_ready handshake; is_load, is_store, func3, addr, store_data, dest_i.
// Memory    : dmem_req/dmem_ack handshake; dmem_we, dmem_addr (word aligned), dmem_wdata,
//             dmem_wstrb out; dmem_rdata in (valid with dmem_ack).
// Writeback : wb_valid single-cycle pulse with wb_dest/wb_data.
// fault     : single-cycle pulse for a misaligned access or illegal func3.
// reset is asynchronous and active-low. One transaction at most is outstanding.
module mem_stage
    import mriscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      dest_i,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_dest,
    output logic [XLEN-1:0] wb_data,
    output logic            fault
);

    mem_state_e      state_r, state_next_s;
    logic            we_r, we_next_s;
    logic [XLEN-1:0] maddr_r, maddr_next_s;
    logic [XLEN-1:0] wdata_r, wdata_next_s;
    logic [3:0]      wstrb_r, wstrb_next_s;
    logic [2:0]      ld_f3_r, ld_f3_next_s;
    logic [1:0]      ld_off_r, ld_off_next_s;
    logic [4:0]      ld_dest_r, ld_dest_next_s;
    logic            wb_valid_r, wb_valid_next_s;
    logic [4:0]      wb_dest_r, wb_dest_next_s;
    logic [XLEN-1:0] wb_data_r, wb_data_next_s;
    logic            fault_r, fault_next_s;

    logic [XLEN-1:0] al_wdata_s;
    logic [3:0]      al_wstrb_s;
    logic            al_ok_s;
    logic [XLEN-1:0] al_ld_data_s;

    mem_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .func3      (func3),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .wdata      (al_wdata_s),
        .wstrb      (al_wstrb_s),
        .access_ok  (al_ok_s),
        .ld_func3   (ld_f3_r),
        .ld_off     (ld_off_r),
        .rdata      (dmem_rdata),
        .ld_data    (al_ld_data_s)
    );

    // Next-state and next-output logic for the IDLE/WAIT controller
    always_comb begin
        state_next_s    = state_r;
        we_next_s       = we_r;
        maddr_next_s    = maddr_r;
        wdata_next_s    = wdata_r;
        wstrb_next_s    = wstrb_r;
        ld_f3_next_s    = ld_f3_r;
        ld_off_next_s   = ld_off_r;
        ld_dest_next_s  = ld_dest_r;
        wb_valid_next_s = 1'b0;
        wb_dest_next_s  = wb_dest_r;
        wb_data_next_s  = wb_data_r;
        fault_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_load || is_store) begin
                        if (al_ok_s) begin
                            // Capture the whole request so it stays stable while waiting
                            state_next_s   = ST_WAIT;
                            we_next_s      = is_store & ~is_load;
                            maddr_next_s   = {addr[XLEN-1:2], 2'b00};
                            wdata_next_s   = al_wdata_s;
                            wstrb_next_s   = al_wstrb_s;
                            ld_f3_next_s   = func3;
                            ld_off_next_s  = addr[1:0];
                            ld_dest_next_s = dest_i;
                        end else begin
                            fault_next_s = 1'b1;
                        end
                    end else begin
                        wb_valid_next_s = 1'b1;
                        wb_data_next_s  = addr;
                        wb_dest_next_s  = dest_i;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_next_s = ST_IDLE;
                    if (!we_r) begin
                        wb_valid_next_s = 1'b1;
                        wb_data_next_s  = al_ld_data_s;
                        wb_dest_next_s  = ld_dest_r;
                    end else begin
                        wb_valid_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            maddr_r    <= {XLEN{1'b0}};
            wdata_r    <= {XLEN{1'b0}};
            wstrb_r    <= 4'b0000;
            ld_f3_r    <= 3'b000;
            ld_off_r   <= 2'b00;
            ld_dest_r  <= 5'd0;
            wb_valid_r <= 1'b0;
            wb_dest_r  <= 5'd0;
            wb_data_r  <= {XLEN{1'b0}};
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            we_r       <= we_next_s;
            maddr_r    <= maddr_next_s;
            wdata_r    <= wdata_next_s;
            wstrb_r    <= wstrb_next_s;
            ld_f3_r    <= ld_f3_next_s;
            ld_off_r   <= ld_off_next_s;
            ld_dest_r  <= ld_dest_next_s;
            wb_valid_r <= wb_valid_next_s;
            wb_dest_r  <= wb_dest_next_s;
            wb_data_r  <= wb_data_next_s;
            fault_r    <= fault_next_s;
        end
    end

    // Handshake outputs are direct decodes of the state flop, so reset clears dmem_req at once
    assign in_ready   = (state_r == ST_IDLE);
    assign dmem_req   = (state_r == ST_WAIT);
    assign dmem_we    = we_r;
    assign dmem_addr  = maddr_r;
    assign dmem_wdata = wdata_r;
    assign dmem_wstrb = wstrb_r;
    assign wb_valid   = wb_valid_r;
    assign wb_dest    = wb_dest_r;
    assign wb_data    = wb_data_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of directed vectors plus hand-written
// sequences for wait states, stray ack, and reset during WAIT.
module tb_mem_stage;
    import mriscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  dest_i = 5'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .func3(func3), .addr(addr),
        .store_data(store_data), .dest_i(dest_i), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .fault(fault)
    );

    // kind: 0 pass-through, 1 load, 2 store, 3 fault
    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic [31:0] rd;
        int          kind;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_wb;
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one instruction for exactly one accepting edge
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1; is_load = ld; is_store = st; func3 = f3;
        addr = a; store_data = sd; dest_i = d;
        @(posedge clk); #1;
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        func3 = 3'b000; addr = 32'h0; store_data = 32'h0; dest_i = 5'd0;
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5,  32'h0,         0, 32'h0, 32'h0,         4'b0000, 32'h0000_1234};
        vt[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 5'd3, 32'h0,  2, 32'h100, 32'hABAB_ABAB, 4'b1000, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 5'd6,  32'h0000_8000, 1, 32'h100, 32'h0,         4'b0000, 32'hFFFF_FF80};
        vt[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd7,  32'h0000_8000, 1, 32'h100, 32'h0,         4'b0000, 32'h0000_0080};
        vt[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd8,  32'h8001_0000, 1, 32'h100, 32'h0,         4'b0000, 32'hFFFF_8001};
        vt[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd9,  32'h8001_0000, 1, 32'h100, 32'h0,         4'b0000, 32'h0000_8001};
        vt[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd10, 32'h0,         3, 32'h0,   32'h0,         4'b0000, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd11, 32'hDEAD_BEEF, 1, 32'h100, 32'h0,         4'b0000, 32'hDEAD_BEEF};
        vt[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd12, 32'h0, 2, 32'h100, 32'hABCD_ABCD, 4'b1100, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 5'd13, 32'h0, 2, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'h0};
        vt[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd14, 32'h0,         3, 32'h0,   32'h0,         4'b0000, 32'h0};
        vt[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd15, 32'h0,         3, 32'h0,   32'h0,         4'b0000, 32'h0};
        vt[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd16, 32'h0,         3, 32'h0,   32'h0,         4'b0000, 32'h0};
        vt[13] = '{1'b1, 1'b1, 3'b000, 32'h0000_0102, 32'h5555_5555, 5'd17, 32'h00FF_0000, 1, 32'h100, 32'h0, 4'b0000, 32'hFFFF_FFFF};
        vt[14] = '{1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd0,  32'h0,         0, 32'h0,   32'h0,         4'b0000, 32'hFFFF_FFFF};
        vt[15] = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 5'd18, 32'h7F00_0000, 1, 32'h200, 32'h0,         4'b0000, 32'h0000_007F};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset = 1'b1;

        // Table-driven vectors, zero-wait acknowledge
        for (int i = 0; i < NV; i++) begin
            issue(vt[i].ld, vt[i].st, vt[i].f3, vt[i].a, vt[i].sd, vt[i].dest);
            @(negedge clk);
            case (vt[i].kind)
                0: begin
                    chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
                    chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].e_wb);
                    chk($sformatf("v%0d_wb_dest", i), 32'(wb_dest), 32'(vt[i].dest));
                    chk($sformatf("v%0d_no_req", i), 32'(dmem_req), 32'd0);
                end
                3: begin
                    chk($sformatf("v%0d_fault", i), 32'(fault), 32'd1);
                    chk($sformatf("v%0d_no_req", i), 32'(dmem_req), 32'd0);
                    chk($sformatf("v%0d_no_wb", i), 32'(wb_valid), 32'd0);
                    chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
                end
                default: begin
                    chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'd1);
                    chk($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
                    chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].e_addr);
                    chk($sformatf("v%0d_we", i), 32'(dmem_we), (vt[i].kind == 2) ? 32'd1 : 32'd0);
                    chk($sformatf("v%0d_wstrb", i), 32'(dmem_wstrb), 32'(vt[i].e_strb));
                    if (vt[i].kind == 2) begin
                        chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wdata);
                    end
                    dmem_ack = 1'b1; dmem_rdata = vt[i].rd;
                    @(posedge clk); #1;
                    dmem_ack = 1'b0; dmem_rdata = 32'h0;
                    @(negedge clk);
                    chk($sformatf("v%0d_req_drop", i), 32'(dmem_req), 32'd0);
                    chk($sformatf("v%0d_ready_back", i), 32'(in_ready), 32'd1);
                    chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), (vt[i].kind == 1) ? 32'd1 : 32'd0);
                    if (vt[i].kind == 1) begin
                        chk($sformatf("v%0d_wb_data", i), wb_data, vt[i].e_wb);
                        chk($sformatf("v%0d_wb_dest", i), 32'(wb_dest), 32'(vt[i].dest));
                    end
                end
            endcase
            @(negedge clk);
            chk($sformatf("v%0d_wb_pulse", i), 32'(wb_valid), 32'd0);
            chk($sformatf("v%0d_fault_pulse", i), 32'(fault), 32'd0);
        end

        // sb with three wait cycles: request must hold stable
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd4);
        @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("sbw%0d_req", w), 32'(dmem_req), 32'd1);
            chk($sformatf("sbw%0d_addr", w), dmem_addr, 32'h0000_0100);
            chk($sformatf("sbw%0d_wdata", w), dmem_wdata, 32'hABAB_ABAB);
            chk($sformatf("sbw%0d_wstrb", w), 32'(dmem_wstrb), 32'(4'b1000));
            chk($sformatf("sbw%0d_we", w), 32'(dmem_we), 32'd1);
            chk($sformatf("sbw%0d_no_wb", w), 32'(wb_valid), 32'd0);
            if (w < 3) @(negedge clk);
        end
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("sbw_req_drop", 32'(dmem_req), 32'd0);
        chk("sbw_no_wb", 32'(wb_valid), 32'd0);
        chk("sbw_ready", 32'(in_ready), 32'd1);

        // Stray ack while idle is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        chk("stray_ack_wb", 32'(wb_valid), 32'd0);
        chk("stray_ack_req", 32'(dmem_req), 32'd0);
        chk("stray_ack_ready", 32'(in_ready), 32'd1);

        // Reset during WAIT abandons the transaction; late ack ignored
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd7);
        @(negedge clk);
        chk("rw_req", 32'(dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rw_req_async_drop", 32'(dmem_req), 32'd0);
        chk("rw_ready_async", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        chk("rw_late_ack_wb", 32'(wb_valid), 32'd0);
        chk("rw_late_ack_req", 32'(dmem_req), 32'd0);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 5'd21);
        @(negedge clk);
        chk("rw_next_req", 32'(dmem_req), 32'd1);
        chk("rw_next_addr", dmem_addr, 32'h0000_0200);
        dmem_ack = 1'b1; dmem_rdata = 32'hAA00_0000;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        chk("rw_next_wb_valid", 32'(wb_valid), 32'd1);
        chk("rw_next_wb_data", wb_data, 32'h0000_00AA);
        chk("rw_next_wb_dest", 32'(wb_dest), 32'd21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
